// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter: latches button press pulses and serializes them onto a valid/ready event port.
// Optional overrun flags are enabled by defining BTN_OVERRUN_EN.
module btn_event_arbiter #(
  parameter int unsigned N_BTN   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned GAP_CYC = 0,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [ID_W-1:0]  ev_id,
  output logic [N_BTN-1:0] ev_onehot,
  output logic [N_BTN-1:0] pending,
`ifdef BTN_OVERRUN_EN
  output logic [N_BTN-1:0] ovr,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

  state_e           state_q, state_d;
  logic [N_BTN-1:0] pending_q, pending_d, clr;
  logic             ev_valid_q, ev_valid_d;
  logic [ID_W-1:0]  ev_id_q, ev_id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  pick;
  logic             found;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign accept = ev_valid_q & ev_ready;

  always_comb begin
    clr = '0;
    if (accept) clr[ev_id_q] = 1'b1;
  end

  // A new press on the bit being cleared stays queued.
  assign pending_d = (pending_q & ~clr) | btn_pulse;

  // First pending bit after last_q, wrapping modulo N_BTN.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] sel;
    idx   = 0;
    sel   = '0;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_BTN; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      sel = ID_W'(idx);
      if (!found && pending_q[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ev_valid_d = ev_valid_q;
    ev_id_d    = ev_id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          ev_id_d    = pick;
          ev_valid_d = 1'b1;
          state_d    = StPresent;
        end
      end
      StPresent: begin
        if (accept) begin
          ev_valid_d = 1'b0;
          last_d     = ev_id_q;
          if (GAP_CYC > 0) begin
            state_d = StGap;
            cnt_d   = CNT_W'(GAP_CYC - 1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        ev_valid_d = 1'b0;
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d    = StIdle;
        ev_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      last_q     <= ID_W'(N_BTN - 1);
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ev_valid_q <= ev_valid_d;
      ev_id_q    <= ev_id_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef BTN_OVERRUN_EN
  logic [N_BTN-1:0] ovr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovr_q <= '0;
    else      ovr_q <= ovr_q | (btn_pulse & pending_q & ~clr);
  end

  assign ovr = ovr_q;
`endif

  always_comb begin
    ev_onehot = '0;
    if (ev_valid_q) ev_onehot[ev_id_q] = 1'b1;
  end

  assign ev_valid = ev_valid_q;
  assign ev_id    = ev_id_q;
  assign pending  = pending_q;
  assign busy     = (state_q != StIdle);

endmodule
